// File: rtl/uart_tx_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// w8 is declared here so that the block does not depend on an external typedefs header.
package uart_tx_arb_pkg;

    typedef logic [7:0] w8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        DRAIN     = 2'd3
    } tx_arb_state_t;

    localparam int BUSY_WAIT_DEFAULT = 4;

endpackage

// File: rtl/tx_arb_pick2.sv
// Two-way grant selection for the UART transmit arbiter.
// Round-robin when UART_TX_ARB_ROUND_ROBIN_EN is defined, fixed priority (port 0 first) otherwise.
module tx_arb_pick2 (
    input  logic [1:0] req_valid,
    input  logic       last,
    output logic       grant
);

    always_comb begin
        grant = last;
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
        case (req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last;
            default: grant = last;
        endcase
`else
        if (req_valid[0]) begin
            grant = 1'b0;
        end else if (req_valid[1]) begin
            grant = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UartTx between the boot loader (port 0) and the core send path (port 1),
// one byte at a time. Arbitration policy selected by UART_TX_ARB_ROUND_ROBIN_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | offering req_ready to the granted port, waiting for a byte
// LAUNCH    | tx_start pulse for the captured byte
// WAIT_BUSY | waiting up to BUSY_WAIT cycles for tx_busy to rise
// DRAIN     | frame in progress, waiting for tx_busy to fall
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int BUSY_WAIT = BUSY_WAIT_DEFAULT
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [1:0] req_valid,
    input  w8          req_data0,
    input  w8          req_data1,
    output logic [1:0] req_ready,
    output logic       tx_start,
    output w8          sdata,
    input  logic       tx_busy,
    output logic       owner,
    output logic       active,
    output logic       tx_err
);

    localparam int CNT_W = $clog2(BUSY_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(BUSY_WAIT);

    tx_arb_state_t    state;
    logic             last;
    logic             grant;
    logic             accept;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_inc;

    tx_arb_pick2 u_pick (
        .req_valid (req_valid),
        .last      (last),
        .grant     (grant)
    );

    // Outputs are held off while resetn is low so an abandoned LAUNCH cannot leak a pulse.
    always_comb begin
        req_ready = 2'b00;
        if (resetn && (state == IDLE) && !tx_busy) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign accept       = |(req_valid & req_ready);
    assign tx_start     = resetn && (state == LAUNCH);
    assign active       = (state != IDLE);
    assign wait_cnt_inc = (wait_cnt == WAIT_LIMIT) ? wait_cnt : wait_cnt + CNT_W'(1);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state    <= IDLE;
            sdata    <= '0;
            owner    <= 1'b0;
            last     <= 1'b1;
            tx_err   <= 1'b0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sdata <= grant ? req_data1 : req_data0;
                        owner <= grant;
                        state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    wait_cnt <= '0;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= DRAIN;
                    end else begin
                        wait_cnt <= wait_cnt_inc;
                        // Lost byte: flag it and move on, no retry.
                        if (wait_cnt_inc == WAIT_LIMIT) begin
                            tx_err <= 1'b1;
                            last   <= owner;
                            state  <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (!tx_busy) begin
                        last  <= owner;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter; tx_busy is driven by hand in place of UartTx.
// Expected values follow the arbitration policy selected by UART_TX_ARB_ROUND_ROBIN_EN.
module tb_uart_tx_arbiter;

    logic       clock = 1'b0;
    logic       resetn;
    logic [1:0] req_valid;
    logic [7:0] req_data0;
    logic [7:0] req_data1;
    logic [1:0] req_ready;
    logic       tx_start;
    logic [7:0] sdata;
    logic       tx_busy;
    logic       owner;
    logic       active;
    logic       tx_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    uart_tx_arbiter #(.BUSY_WAIT(4)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_ready (req_ready),
        .tx_start  (tx_start),
        .sdata     (sdata),
        .tx_busy   (tx_busy),
        .owner     (owner),
        .active    (active),
        .tx_err    (tx_err)
    );

    // Entered at the negedge of the LAUNCH cycle; returns at the negedge after DRAIN exits.
    task automatic run_frame(input int len);
        @(negedge clock);
        tx_busy = 1'b1;
        for (int i = 0; i < len; i++) begin
            @(negedge clock);
            n_cmp++;
            if (tx_start !== 1'b0 || req_ready !== 2'b00) begin
                n_bad++;
                $display("FAIL frame_overlap: tx_start=%b req_ready=%b, want 0/00", tx_start, req_ready);
            end
        end
        tx_busy = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 2'b00) begin
            n_bad++;
            $display("FAIL drain_hold: req_ready=%b want 00", req_ready);
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        req_valid = 2'b00;
        req_data0 = 8'h00;
        req_data1 = 8'h00;
        tx_busy   = 1'b0;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        #1;
        n_cmp++;
        if ({tx_start, active, tx_err, owner} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags: start/active/err/owner=%b want 0000",
                     {tx_start, active, tx_err, owner});
        end
        n_cmp++;
        if (sdata !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_sdata: got %h want 00", sdata);
        end
        n_cmp++;
        if (req_ready !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 10", req_ready);
        end
    endtask

    task automatic test_single();
        req_valid = 2'b10;
        req_data1 = 8'h41;
        #1;
        n_cmp++;
        if (req_ready !== 2'b10) begin
            n_bad++;
            $display("FAIL single_ready: got %b want 10", req_ready);
        end
        @(negedge clock);
        req_data1 = 8'h42;
        #1;
        n_cmp++;
        if (tx_start !== 1'b1 || sdata !== 8'h41 || owner !== 1'b1 || active !== 1'b1) begin
            n_bad++;
            $display("FAIL single_launch: start=%b sdata=%h owner=%b active=%b want 1/41/1/1",
                     tx_start, sdata, owner, active);
        end
        run_frame(3);
        #1;
        n_cmp++;
        if (req_ready !== 2'b10 || active !== 1'b0) begin
            n_bad++;
            $display("FAIL single_rearm: ready=%b active=%b want 10/0", req_ready, active);
        end
        @(negedge clock);
        req_valid = 2'b00;
        #1;
        n_cmp++;
        if (tx_start !== 1'b1 || sdata !== 8'h42) begin
            n_bad++;
            $display("FAIL single_second: start=%b sdata=%h want 1/42", tx_start, sdata);
        end
        run_frame(2);
    endtask

    task automatic test_arbitration();
        logic [7:0] exp_b [4];
        logic [1:0] exp_r [4];
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
        exp_b = '{8'h10, 8'h20, 8'h10, 8'h20};
        exp_r = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_b = '{8'h10, 8'h10, 8'h10, 8'h10};
        exp_r = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        req_data0 = 8'h10;
        req_data1 = 8'h20;
        for (int k = 0; k < 4; k++) begin
            req_valid = 2'b11;
            #1;
            n_cmp++;
            if (req_ready !== exp_r[k]) begin
                n_bad++;
                $display("FAIL arb_ready[%0d]: got %b want %b", k, req_ready, exp_r[k]);
            end
            @(negedge clock);
            #1;
            n_cmp++;
            if (tx_start !== 1'b1 || sdata !== exp_b[k]) begin
                n_bad++;
                $display("FAIL arb_byte[%0d]: start=%b sdata=%h want 1/%h", k, tx_start, sdata, exp_b[k]);
            end
            run_frame(3);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_timeout();
        req_valid = 2'b01;
        req_data0 = 8'h55;
        @(negedge clock);
        req_valid = 2'b00;
        #1;
        n_cmp++;
        if (tx_start !== 1'b1 || sdata !== 8'h55) begin
            n_bad++;
            $display("FAIL to_launch: start=%b sdata=%h want 1/55", tx_start, sdata);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            n_cmp++;
            if (active !== 1'b1 || tx_err !== 1'b0 || tx_start !== 1'b0) begin
                n_bad++;
                $display("FAIL to_wait[%0d]: active=%b err=%b start=%b want 1/0/0", c, active, tx_err, tx_start);
            end
        end
        @(negedge clock);
        n_cmp++;
        if (active !== 1'b0 || tx_err !== 1'b1) begin
            n_bad++;
            $display("FAIL to_expire: active=%b err=%b want 0/1", active, tx_err);
        end
        req_valid = 2'b10;
        req_data1 = 8'h77;
        #1;
        n_cmp++;
        if (req_ready !== 2'b10) begin
            n_bad++;
            $display("FAIL to_after_ready: got %b want 10", req_ready);
        end
        @(negedge clock);
        req_valid = 2'b00;
        run_frame(2);
        n_cmp++;
        if (tx_err !== 1'b1) begin
            n_bad++;
            $display("FAIL to_sticky: err=%b want 1", tx_err);
        end
    endtask

    task automatic test_foreign_busy();
        req_data0 = 8'h10;
        req_data1 = 8'h20;
        req_valid = 2'b11;
        tx_busy   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (req_ready !== 2'b00 || active !== 1'b0 || tx_start !== 1'b0) begin
                n_bad++;
                $display("FAIL foreign[%0d]: ready=%b active=%b start=%b want 00/0/0", c, req_ready, active, tx_start);
            end
            @(negedge clock);
        end
        tx_busy = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_bad++;
            $display("FAIL foreign_release: got %b want 01", req_ready);
        end
        @(negedge clock);
        req_valid = 2'b00;
        #1;
        n_cmp++;
        if (tx_start !== 1'b1 || sdata !== 8'h10 || owner !== 1'b0) begin
            n_bad++;
            $display("FAIL foreign_launch: start=%b sdata=%h owner=%b want 1/10/0", tx_start, sdata, owner);
        end
    endtask

    // Continues from the LAUNCH cycle left by test_foreign_busy.
    task automatic test_reset_in_drain();
        @(negedge clock);
        tx_busy = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (active !== 1'b1 || tx_err !== 1'b1) begin
            n_bad++;
            $display("FAIL drain_pre: active=%b err=%b want 1/1", active, tx_err);
        end
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (tx_start !== 1'b0 || req_ready !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_cycle: start=%b ready=%b want 0/00", tx_start, req_ready);
        end
        @(negedge clock);
        n_cmp++;
        if ({active, tx_err, tx_start, owner} !== 4'b0000 || sdata !== 8'h00) begin
            n_bad++;
            $display("FAIL rst_state: active/err/start/owner=%b sdata=%h want 0000/00",
                     {active, tx_err, tx_start, owner}, sdata);
        end
        resetn  = 1'b1;
        tx_busy = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (tx_start !== 1'b0 || active !== 1'b0 || req_ready !== 2'b10) begin
            n_bad++;
            $display("FAIL rst_after: start=%b active=%b ready=%b want 0/0/10", tx_start, active, req_ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_arbitration();
        test_timeout();
        test_foreign_busy();
        test_reset_in_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
